// File: rtl/tuner_fft_pkg.sv
// Shared defaults, error code and input-FSM type for the TunerFFT frame feeder.
package tuner_fft_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_FFTPTS_W = 14;
   localparam int unsigned DEF_SAMPLE_W = 16;

   localparam logic [1:0] FFT_ERR_NONE = 2'b00;

   typedef enum logic {
      IN_IDLE    = 1'b0,
      IN_CAPTURE = 1'b1
   } in_state_e;

endpackage

// File: rtl/fft_frame_feeder_if.sv
// Source-side streaming bus from the frame feeder into the TunerFFT sink port.
interface fft_frame_feeder_if
   import tuner_fft_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned FFTPTS_W = DEF_FFTPTS_W
);

   logic                src_valid;
   logic                src_ready;
   logic                src_sop;
   logic                src_eop;
   logic [DATA_W-1:0]   src_real;
   logic [DATA_W-1:0]   src_imag;
   logic [1:0]          src_error;
   logic [FFTPTS_W-1:0] fftpts;

   modport master (
      output src_valid, src_sop, src_eop, src_real, src_imag, src_error, fftpts,
      input  src_ready
   );

   modport slave (
      input  src_valid, src_sop, src_eop, src_real, src_imag, src_error, fftpts,
      output src_ready
   );

endinterface

// File: rtl/fft_feed_fifo.sv
// Single-clock FIFO with a lookahead peek port (head or head+1) so the
// feeder's output register can reload in the same cycle it is drained.
module fft_feed_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic                     peek_next,
   output logic [WIDTH-1:0]         peek_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_wr, do_rd;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      do_rd    = rd_en && (count_q != '0);
      // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
      do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(do_wr) - CW'(do_rd);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign peek_data = mem_q[rd_ptr_q + AW'(peek_next)];
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers PCM samples and streams them to TunerFFT as sop/eop-framed words.
// Optional build macro FEEDER_DECIM_EN keeps only every DECIM-th sample strobe.
module fft_frame_feeder
   import tuner_fft_pkg::*;
#(
   parameter int unsigned FFT_POINTS = 1024,
   parameter int unsigned FFTPTS_W   = DEF_FFTPTS_W,
   parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH = 2048,
   parameter int unsigned DECIM      = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   fft_frame_feeder_if.master  src,
   output logic                overflow,
   output logic                frame_done
);

   localparam int unsigned CNT_W = $clog2(FFT_POINTS);
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_POINTS - 1);

   in_state_e         state_q, state_d;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              overflow_q, overflow_d;
   logic              frame_done_q, frame_done_d;

   logic              capture_active;
   logic              keep_strobe;
   logic              candidate;
   logic              accepted;
   logic              dropped;
   logic              xfer;
   logic              load;

   logic [DATA_W-1:0] wr_word;
   logic [DATA_W-1:0] fifo_peek;
   logic              fifo_full;
   logic              fifo_empty;
   logic [OCC_W-1:0]  fifo_count;

   // Input FSM: state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IN_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Input FSM: next state. Capture only stops on a frame boundary.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IN_IDLE:    if (enable) state_d = IN_CAPTURE;
         IN_CAPTURE: if (!enable && (in_cnt_q == '0)) state_d = IN_IDLE;
         default:    state_d = IN_IDLE;
      endcase
   end

   // Input FSM: outputs. The closing cycle itself must not start a new frame.
   always_comb begin
      capture_active = (state_q == IN_CAPTURE) && (enable || (in_cnt_q != '0));
      candidate      = capture_active && sample_valid && keep_strobe;
      accepted       = candidate && (!fifo_full || xfer);
      dropped        = candidate && fifo_full && !xfer;
   end

`ifdef FEEDER_DECIM_EN
   localparam int unsigned DEC_W = $clog2(DECIM);

   logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;

   // Strobe 0 after entering capture is kept, then every DECIM-th one.
   always_comb begin
      keep_strobe = (dec_cnt_q == '0);
      dec_cnt_d   = dec_cnt_q;
      if ((state_q == IN_IDLE) && enable) begin
         dec_cnt_d = '0;
      end else if (capture_active && sample_valid) begin
         dec_cnt_d = (dec_cnt_q == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_q + DEC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_cnt_q <= '0;
      end else begin
         dec_cnt_q <= dec_cnt_d;
      end
   end
`else
   logic unused_decim;

   assign keep_strobe  = 1'b1;
   assign unused_decim = (DECIM != 0);
`endif

   assign wr_word = DATA_W'($signed(sample_data));
   assign xfer    = out_valid_q & src.src_ready;

   // The presented word stays in the FIFO until transferred, so the output
   // register reloads from head+1 on a transfer and from head when empty.
   always_comb begin
      load         = xfer ? (fifo_count > OCC_W'(1)) : (!out_valid_q && !fifo_empty);
      out_valid_d  = load | (out_valid_q & ~xfer);
      out_data_d   = load ? fifo_peek : out_data_q;
      out_cnt_d    = xfer ? out_cnt_q + CNT_W'(1) : out_cnt_q;
      in_cnt_d     = accepted ? in_cnt_q + CNT_W'(1) : in_cnt_q;
      overflow_d   = overflow_q | dropped;
      frame_done_d = xfer && (out_cnt_q == LAST_IDX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   fft_feed_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (accepted),
      .wr_data   (wr_word),
      .rd_en     (xfer),
      .peek_next (out_valid_q),
      .peek_data (fifo_peek),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign src.src_valid = out_valid_q;
   assign src.src_real  = out_data_q;
   assign src.src_sop   = out_valid_q && (out_cnt_q == '0);
   assign src.src_eop   = out_valid_q && (out_cnt_q == LAST_IDX);
   assign src.src_imag  = '0;
   assign src.src_error = FFT_ERR_NONE;
   assign src.fftpts    = FFTPTS_W'(FFT_POINTS);

   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomized bench for fft_frame_feeder (8-point frames, 16-entry FIFO)
// checked against a transaction-level model of accepted samples and frame positions.
module tb_fft_frame_feeder;

   localparam int FP    = 8;
   localparam int DEPTH = 16;
   localparam int DECIM = 4;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        overflow;
   logic        frame_done;

   fft_frame_feeder_if #(.DATA_W(32), .FFTPTS_W(14)) sif ();

   fft_frame_feeder #(
      .FFT_POINTS (FP),
      .FFTPTS_W   (14),
      .SAMPLE_W   (16),
      .DATA_W     (32),
      .FIFO_DEPTH (DEPTH),
      .DECIM      (DECIM)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .src          (sif),
      .overflow     (overflow),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] exp_q[$];
   int          m_oidx;
   int          m_icnt;
   int          m_dec;
   bit          m_cap;
   bit          m_ovf;
   bit          m_fd;
   int          m_xfers;
   int          m_frames;
   bit          stall_prev;
   logic [31:0] prev_real;
   logic        prev_sop, prev_eop;

   always @(negedge clk) begin
      int   occ;
      bit   xfer;
      bit   keep;
      logic [31:0] w;
      if (reset) begin
         exp_q.delete();
         m_oidx = 0; m_icnt = 0; m_dec = 0;
         m_cap = 0; m_ovf = 0; m_fd = 0; stall_prev = 0;
      end else begin
         occ  = exp_q.size();
         xfer = sif.src_valid && sif.src_ready;
         check("overflow", overflow, m_ovf);
         check("frame_done", frame_done, m_fd);
         if (frame_done === 1'b1) m_frames++;
         if (stall_prev) begin
            check("stall_valid", sif.src_valid, 1'b1);
            check("stall_real", sif.src_real, prev_real);
            check("stall_sop", sif.src_sop, prev_sop);
            check("stall_eop", sif.src_eop, prev_eop);
         end
         m_fd = 0;
         if (xfer) begin
            if (occ == 0) begin
               check("spurious_word", sif.src_valid, 1'b0);
            end else begin
               w = exp_q.pop_front();
               check("real", sif.src_real, w);
               check("sop", sif.src_sop, m_oidx == 0);
               check("eop", sif.src_eop, m_oidx == FP - 1);
               check("imag", sif.src_imag, 32'd0);
               check("error", sif.src_error, 2'b00);
               check("fftpts", sif.fftpts, 14'd8);
               m_fd   = (m_oidx == FP - 1);
               m_oidx = (m_oidx + 1) % FP;
               m_xfers++;
            end
         end
         stall_prev = sif.src_valid && !sif.src_ready;
         prev_real  = sif.src_real;
         prev_sop   = sif.src_sop;
         prev_eop   = sif.src_eop;

         // Input side: frame-granular capture, drops only when the buffer is full.
         if (!m_cap) begin
            if (enable) begin
               m_cap = 1;
               m_dec = 0;
            end
         end else if (!enable && m_icnt == 0) begin
            m_cap = 0;
         end else if (sample_valid) begin
            keep = 1;
`ifdef FEEDER_DECIM_EN
            keep  = (m_dec % DECIM) == 0;
            m_dec = m_dec + 1;
`endif
            if (keep) begin
               if (occ - int'(xfer) < DEPTH) begin
                  exp_q.push_back(32'(int'($signed(sample_data))));
                  m_icnt = (m_icnt + 1) % FP;
               end else begin
                  m_ovf = 1;
               end
            end
         end
      end
   end

   // ---------------- ready driver ----------------
   int rdy_mode = 0;  // 0: always, 1: 1-0-0 pattern, 2: random, 3: never
   int rdy_ph   = 0;

   initial begin
      sif.src_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       sif.src_ready = 1'b1;
            1:       sif.src_ready = (rdy_ph % 3 == 0);
            2:       sif.src_ready = ($urandom_range(0, 1) == 1);
            default: sif.src_ready = 1'b0;
         endcase
         rdy_ph++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         tick();
         n++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      repeat (6) tick();
      @(negedge clk);
      check({tag, "_idle"}, sif.src_valid, 1'b0);
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, sif.src_valid, 1'b0);
      check({tag, "_sop"}, sif.src_sop, 1'b0);
      check({tag, "_eop"}, sif.src_eop, 1'b0);
      check({tag, "_real"}, sif.src_real, 32'd0);
      check({tag, "_imag"}, sif.src_imag, 32'd0);
      check({tag, "_error"}, sif.src_error, 2'b00);
      check({tag, "_overflow"}, overflow, 1'b0);
      check({tag, "_frame_done"}, frame_done, 1'b0);
      check({tag, "_fftpts"}, sif.fftpts, 14'd8);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      int start;
      int frames0;
      int n;
      reset        = 1'b1;
      enable       = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

      // Basic frame with latency check on the first word.
      rdy_mode = 0;
      enable   = 1'b1;
      tick();
      sample_valid = 1'b1;
      sample_data  = 16'd1;
      tick();
      sample_valid = 1'b0;
      @(negedge clk);
      check("latency_n1", sif.src_valid, 1'b0);
      tick();
      @(negedge clk);
      check("latency_n2", sif.src_valid, 1'b1);
      tick();
      for (int i = 2; i <= 8; i++) drive(16'(i));
      drain("basic");

      // Sign extension and extremes.
      drive(16'h8000);
      drive(16'h7FFF);
      drive(16'hFFFF);
      drive(16'h0001);
      for (int i = 0; i < 4; i++) drive(16'($urandom));
      drain("signext");

      // Backpressure with the 1-0-0 ready pattern.
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) drive(16'($urandom));
      drain("backpressure");

      // Enable dropped mid-frame: the frame completes, later samples are ignored.
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) drive(16'(100 + i));
      enable = 1'b0;
      for (int i = 0; i < 6; i++) drive(16'(200 + i));
      for (int i = 0; i < 3; i++) drive(16'(300 + i));
      drain("enable_drop");

      // Overflow with the sink stalled, then release.
      rdy_mode = 3;
      enable   = 1'b1;
      tick();
      for (int i = 1; i <= 20; i++) drive(16'(i));
      enable = 1'b0;
      repeat (3) tick();
`ifndef FEEDER_DECIM_EN
      check("overflow_set", overflow, 1'b1);
`endif
      frames0  = m_frames;
      rdy_mode = 0;
      drain("overflow");
`ifndef FEEDER_DECIM_EN
      check("overflow_frames", m_frames - frames0, 2);
`endif

      // Randomized traffic: random enable, strobes, data and ready.
      rdy_mode = 2;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 60; c++) begin
            enable       = ($urandom_range(0, 7) != 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_data  = 16'($urandom);
            tick();
         end
         enable = 1'b0;
         n = 0;
         while (m_cap && n < 400) begin
            sample_valid = 1'b1;
            sample_data  = 16'($urandom);
            tick();
            n++;
         end
         sample_valid = 1'b0;
         check("random_close", m_cap, 1'b0);
         drain("random");
      end

      // Reset after five output words, then restart from sop.
      rdy_mode = 1;
      enable   = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) drive(16'(500 + i));
      start = m_xfers;
      n     = 0;
      while (m_xfers < start + 5 && n < 200) begin
         tick();
         n++;
      end
      check("reset_mid_reach", m_xfers - start, 5);
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_mid");
      tick();
      reset = 1'b0;
      tick();
      rdy_mode = 0;
      for (int i = 0; i < 8; i++) drive(16'(600 + i));
      drain("restart");

      enable = 1'b0;
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
